basys3_input_scanner: RTL and testbench

BASYS3_INPUT_SCANNER -- requirements
Module: basys3_input_scanner

---
 rtl/basys3_io_pkg.sv | 31 +++
 rtl/io_debounce.sv | 50 +++++
 rtl/basys3_input_scanner.sv | 131 +++++++++++++
 tb/tb_basys3_input_scanner.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/basys3_io_pkg.sv
// Shared constants for the Basys3 switch/button scanner: input counts,
// event byte layout and the event source encoding.
package basys3_io_pkg;

  localparam int NUM_SW  = 16;
  localparam int NUM_BTN = 5;
  localparam int NUM_IN  = NUM_SW + NUM_BTN;

  // Event byte layout: [7] new level, [6] source, [5] zero, [4:0] index
  localparam int EVT_LEVEL_BIT = 7;
  localparam int EVT_SRC_BIT   = 6;
  localparam int EVT_RSVD_BIT  = 5;
  localparam int EVT_IDX_MSB   = 4;
  localparam int EVT_IDX_LSB   = 0;

  typedef enum logic {
    SRC_SW  = 1'b0,
    SRC_BTN = 1'b1
  } evt_src_e;

  function automatic logic [7:0] make_evt(input logic level, input evt_src_e src,
                                          input logic [4:0] idx);
    logic [7:0] e;
    e                           = '0;
    e[EVT_LEVEL_BIT]            = level;
    e[EVT_SRC_BIT]              = src;
    e[EVT_IDX_MSB:EVT_IDX_LSB]  = idx;
    return e;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One debounced input: two-flop synchronizer, run counter of consecutive
// ticks that disagree with the stable level, and the stable level itself.
// toggle pulses in the cycle whose tick flips the stable level.
module io_debounce #(
  parameter int STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic tick,
  output logic stable,
  output logic toggle
);

  localparam int RW = (STABLE_TICKS < 2) ? 1 : $clog2(STABLE_TICKS + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(STABLE_TICKS - 1);

  logic          sync_a;
  logic          sync_b;
  logic [RW-1:0] run;

  // The run counter clears on acceptance, so it never passes STABLE_TICKS-1.
  assign toggle = tick && (sync_b != stable) && (run == RUN_LAST);

  // Synchronize, count disagreeing ticks and flip the level on acceptance
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      run    <= '0;
      stable <= 1'b0;
    end else begin
      sync_a <= din;
      sync_b <= sync_a;
      if (tick) begin
        if (sync_b != stable) begin
          if (run == RUN_LAST) begin
            stable <= ~stable;
            run    <= '0;
          end else begin
            run <= run + 1'b1;
          end
        end else begin
          run <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/basys3_input_scanner.sv
// Debounces 16 switches and 5 buttons on a shared sample tick and queues one
// event per accepted level change. Changes wait in a pending bit until the
// event queue has room; a second change on a still-pending input is lost and
// raises the sticky overflow flag.
module basys3_input_scanner
  import basys3_io_pkg::*;
#(
  parameter int TICK_DIV     = 10000,
  parameter int STABLE_TICKS = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sw,
  input  logic [4:0]  btn,
  output logic [15:0] sw_state,
  output logic [4:0]  btn_state,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [7:0]  evt_data,
  output logic        overflow,
  input  logic        clear_ovf
);

  localparam int CW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam int AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);

  logic [CW-1:0]     tick_cnt;
  logic              tick;
  logic [NUM_IN-1:0] raw_in;
  logic [NUM_IN-1:0] stable_all;
  logic [NUM_IN-1:0] toggle_all;
  logic [NUM_IN-1:0] pending;
  logic [NUM_IN-1:0] push_mask;
  logic              push_hit;
  logic [4:0]        push_idx;
  logic              push_en;
  logic              push_is_btn;
  logic [4:0]        push_field;
  logic [7:0]        push_data;
  logic              pop_en;
  logic              set_ovf;
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        mem [FIFO_DEPTH];

  assign raw_in = {btn, sw};
  assign tick   = (tick_cnt == TICK_LAST);

  // Free-running sample tick divider
  always_ff @(posedge clk) begin
    if (!reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_db
    io_debounce #(.STABLE_TICKS(STABLE_TICKS)) u_db (
      .clk    (clk),
      .reset  (reset),
      .din    (raw_in[g]),
      .tick   (tick),
      .stable (stable_all[g]),
      .toggle (toggle_all[g])
    );
  end

  assign sw_state  = stable_all[NUM_SW-1:0];
  assign btn_state = stable_all[NUM_IN-1:NUM_SW];

  // Priority encoder: lowest pending bit wins, switches occupy the low bits
  always_comb begin
    push_hit = 1'b0;
    push_idx = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        push_hit = 1'b1;
        push_idx = 5'(i);
      end
    end
  end

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_en     = push_hit && !fifo_full;
  assign pop_en      = !fifo_empty && evt_ready;
  assign push_mask   = push_en ? (NUM_IN'(1) << push_idx) : '0;
  assign push_is_btn = (push_idx >= 5'(NUM_SW));
  assign push_field  = push_is_btn ? (push_idx - 5'(NUM_SW)) : push_idx;
  assign push_data   = make_evt(stable_all[push_idx], push_is_btn ? SRC_BTN : SRC_SW,
                                push_field);

  // A toggle on an input still pending (and not leaving this cycle) loses an event
  assign set_ovf = |(toggle_all & pending & ~push_mask);

  // Pending bits: cleared when pushed, set by any accepted level change
  always_ff @(posedge clk) begin
    if (!reset) pending <= '0;
    else pending <= (pending & ~push_mask) | toggle_all;
  end

  // Sticky overflow; a new loss outranks a clear in the same cycle
  always_ff @(posedge clk) begin
    if (!reset) overflow <= 1'b0;
    else if (set_ovf) overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

  // Queue pointers
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Queue storage; contents are meaningless until the pointers say otherwise
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign evt_valid = !fifo_empty;
  assign evt_data  = fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_basys3_input_scanner.sv
module tb_basys3_input_scanner;

  localparam int TD = 4;
  localparam int ST = 3;
  localparam int FD = 4;
  localparam int NI = 21;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sw = '0;
  logic [4:0]  btn = '0;
  logic        evt_ready = 1'b0;
  logic        clear_ovf = 1'b0;
  logic [15:0] sw_state;
  logic [4:0]  btn_state;
  logic        evt_valid;
  logic [7:0]  evt_data;
  logic        overflow;

  basys3_input_scanner #(.TICK_DIV(TD), .STABLE_TICKS(ST), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .btn       (btn),
    .sw_state  (sw_state),
    .btn_state (btn_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: input history, tick phase, run counts, pending set, queue
  bit         m_s1[NI];
  bit         m_s2[NI];
  bit         m_stable[NI];
  bit         m_pend[NI];
  int         m_run[NI];
  int         m_cnt;
  bit         m_ovf;
  logic [7:0] m_q[$];
  logic [7:0] dut_log[$];
  bit         started = 0;
  bit         m_tk;
  bit         m_set;
  bit         m_tog;
  int         m_pi;
  logic [7:0] m_pd;

  function automatic bit in_bit(input int i);
    return (i < 16) ? sw[i] : btn[i-16];
  endfunction

  always @(posedge clk) begin
    if (reset && evt_valid && evt_ready) dut_log.push_back(evt_data);
    started = 1;
    if (!reset) begin
      for (int i = 0; i < NI; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_stable[i] = 0; m_pend[i] = 0; m_run[i] = 0;
      end
      m_cnt = 0;
      m_ovf = 0;
      m_q.delete();
    end else begin
      m_tk  = (m_cnt == TD - 1);
      m_cnt = (m_cnt + 1) % TD;
      m_pi  = -1;
      if (m_q.size() < FD)
        for (int i = 0; i < NI; i++) if (m_pend[i] && m_pi < 0) m_pi = i;
      if (m_pi >= 0)
        m_pd = {m_stable[m_pi], (m_pi >= 16) ? 1'b1 : 1'b0, 1'b0,
                5'((m_pi >= 16) ? m_pi - 16 : m_pi)};
      if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
      if (m_pi >= 0) m_q.push_back(m_pd);
      m_set = 0;
      for (int i = 0; i < NI; i++) begin
        m_tog = 0;
        if (m_tk) begin
          if (m_s2[i] != m_stable[i]) begin
            m_run[i]++;
            if (m_run[i] >= ST) begin
              m_tog = 1;
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
        if (i == m_pi) m_pend[i] = 0;
        if (m_tog) begin
          if (m_pend[i]) m_set = 1;
          m_pend[i]   = 1;
          m_stable[i] = ~m_stable[i];
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = in_bit(i);
      end
      if (m_set) m_ovf = 1;
      else if (clear_ovf) m_ovf = 0;
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (started) begin
      logic [15:0] e_sw;
      logic [4:0]  e_btn;
      for (int i = 0; i < 16; i++) e_sw[i] = m_stable[i];
      for (int i = 0; i < 5; i++) e_btn[i] = m_stable[16+i];
      chk("model sw_state", 32'(sw_state), 32'(e_sw));
      chk("model btn_state", 32'(btn_state), 32'(e_btn));
      chk("model evt_valid", 32'(evt_valid), 32'(m_q.size() != 0));
      chk("model evt_data", 32'(evt_data), 32'((m_q.size() != 0) ? m_q[0] : 8'h00));
      chk("model overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic chk_log(input int idx, input logic [7:0] exp);
    if (idx < dut_log.size()) chk($sformatf("event[%0d]", idx), 32'(dut_log[idx]), 32'(exp));
    else chk($sformatf("event[%0d] present", idx), 32'(dut_log.size()), 32'(idx + 1));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0; sw = '0; btn = '0; clear_ovf = 0;
    cycles(2);
    reset = 1;
    dut_log.delete();
  endtask

  initial begin
    // Input high through reset debounces into a single rising event
    sw = 16'h0001; evt_ready = 1;
    cycles(3);
    reset = 1;
    cycles(40);
    chk("s1 sw_state", 32'(sw_state), 32'h0001);
    chk("s1 event count", 32'(dut_log.size()), 32'd1);
    chk_log(0, 8'h80);
    dut_log.delete();
    cycles(30);
    chk("s1 no further events", 32'(dut_log.size()), 32'd0);

    // Short button glitch: two ticks only
    do_reset();
    evt_ready = 1;
    btn[2] = 1'b1;
    cycles(8);
    btn[2] = 1'b0;
    cycles(40);
    chk("s2 btn_state", 32'(btn_state), 32'd0);
    chk("s2 event count", 32'(dut_log.size()), 32'd0);

    // Simultaneous rises pop in priority order
    do_reset();
    evt_ready = 1;
    sw = 16'h0009; btn = 5'b00010;
    cycles(40);
    chk("s3 event count", 32'(dut_log.size()), 32'd3);
    chk_log(0, 8'h80);
    chk_log(1, 8'h83);
    chk_log(2, 8'hC1);

    // Fill the queue with the consumer stalled, then drain
    do_reset();
    evt_ready = 0;
    sw = 16'h001F;
    cycles(40);
    chk("s4 evt_valid", 32'(evt_valid), 32'd1);
    chk("s4 head", 32'(evt_data), 32'h80);
    chk("s4 overflow", 32'(overflow), 32'd0);
    evt_ready = 1;
    cycles(20);
    chk("s4 event count", 32'(dut_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk_log(i, 8'h80 + 8'(i));

    // Lost event on a doubly toggled pending input, then clear
    do_reset();
    evt_ready = 0;
    sw = 16'h001F;
    cycles(40);
    sw[5] = 1'b1;
    cycles(40);
    chk("s5 overflow before", 32'(overflow), 32'd0);
    sw[5] = 1'b0;
    cycles(40);
    chk("s5 overflow set", 32'(overflow), 32'd1);
    clear_ovf = 1;
    cycles(1);
    clear_ovf = 0;
    chk("s5 overflow cleared", 32'(overflow), 32'd0);

    // Reset mid-operation discards the queue
    do_reset();
    evt_ready = 0;
    sw = 16'h0003;
    cycles(40);
    chk("s6 queued", 32'(evt_valid), 32'd1);
    reset = 0;
    cycles(1);
    chk("s6 evt_valid after reset", 32'(evt_valid), 32'd0);
    chk("s6 sw_state after reset", 32'(sw_state), 32'd0);
    reset = 1;
    evt_ready = 1;
    cycles(40);
    chk("s6 rises again", 32'(sw_state), 32'h0003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
